// File: rtl/adat_rx_frame_decoder.sv
// ADAT frame decoder: assembles user nibble and channel words from
// 5-bit groups, maps channels to S/MUX slots, buffers words in a FIFO.
module adat_rx_frame_decoder #(
    parameter  int NUM_CH       = 8,
    parameter  int NIB_PER_WORD = 6,
    parameter  int FIFO_DEPTH   = 16,
    localparam int DW           = 4 * NIB_PER_WORD,
    localparam int CW           = $clog2(NUM_CH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [4:0]    i_bits,
    input  logic [2:0]    i_bit_count,
    input  logic          i_valid,
    input  logic          i_sync,
    input  logic [1:0]    i_smux,
    output logic [3:0]    o_user,
    output logic          o_user_valid,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_channel,
    output logic [1:0]    o_slot,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_frame_done,
    output logic          o_frame_err,
    output logic          o_locked,
    output logic          o_overflow
);

    localparam int NW  = (NIB_PER_WORD > 1) ? $clog2(NIB_PER_WORD) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CTW = AW + 1;

    typedef enum logic [1:0] {
        IDLE, USER, DATA, WAIT_SYNC
    } state_t;

    state_t        state, nxt_state, eff;
    logic [NW-1:0] nib, nxt_nib;
    logic [CW-1:0] ch, nxt_ch;
    logic [DW-1:0] word, nxt_word, word_sh;
    logic          push, user_ld, done, err, bad;

    logic [CW-1:0] map_ch;
    logic [1:0]    map_slot;

    logic [DW-1:0] mem_d  [FIFO_DEPTH];
    logic [CW-1:0] mem_c  [FIFO_DEPTH];
    logic [1:0]    mem_s  [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CTW-1:0] count;
    logic          full, pop, do_push;

    assign bad     = (i_bit_count != 3'd5) || !i_bits[0];
    assign word_sh = (word << 4) | DW'(i_bits[4:1]);

    // Next-state, counters, and event decode for the current group
    always_comb begin
        nxt_state = state;
        nxt_nib   = nib;
        nxt_ch    = ch;
        nxt_word  = word;
        push      = 1'b0;
        user_ld   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        eff       = state;
        if (i_sync) begin
            err       = (state == DATA);
            eff       = USER;
            nxt_state = USER;
            nxt_nib   = '0;
            nxt_ch    = '0;
            nxt_word  = '0;
        end
        if (i_valid) begin
            unique case (eff)
                IDLE: ;
                USER: begin
                    if (bad) begin
                        err       = 1'b1;
                        nxt_state = IDLE;
                    end else begin
                        user_ld   = 1'b1;
                        nxt_state = DATA;
                    end
                end
                DATA: begin
                    if (bad) begin
                        err       = 1'b1;
                        nxt_state = IDLE;
                        nxt_nib   = '0;
                        nxt_ch    = '0;
                        nxt_word  = '0;
                    end else if (nib == NW'(NIB_PER_WORD - 1)) begin
                        push     = 1'b1;
                        nxt_nib  = '0;
                        nxt_word = '0;
                        nxt_ch   = ch + CW'(1);
                        if (ch == CW'(NUM_CH - 1)) begin
                            done      = 1'b1;
                            nxt_ch    = '0;
                            nxt_state = WAIT_SYNC;
                        end
                    end else begin
                        nxt_word = word_sh;
                        nxt_nib  = nib + NW'(1);
                    end
                end
                WAIT_SYNC: err = 1'b1;
                default: ;
            endcase
        end
    end

    // S/MUX channel/slot mapping of the word being pushed
    always_comb begin
        map_ch   = ch;
        map_slot = 2'd0;
        unique case (i_smux)
            2'd1: begin
                map_ch   = ch >> 1;
                map_slot = {1'b0, ch[0]};
            end
            2'd2: begin
                map_ch   = ch >> 2;
                map_slot = ch[1:0];
            end
            default: ;
        endcase
    end

    // FSM state and frame assembly registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
            nib   <= '0;
            ch    <= '0;
            word  <= '0;
        end else begin
            state <= nxt_state;
            nib   <= nxt_nib;
            ch    <= nxt_ch;
            word  <= nxt_word;
        end
    end

    // Registered status outputs and pulses
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_user       <= '0;
            o_user_valid <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_locked     <= 1'b0;
        end else begin
            o_user_valid <= user_ld;
            o_frame_done <= done;
            o_frame_err  <= err;
            if (user_ld) o_user <= i_bits[4:1];
            if (done) o_locked <= 1'b1;
            else if (err) o_locked <= 1'b0;
        end
    end

    assign full    = (count == CTW'(FIFO_DEPTH));
    assign pop     = o_valid && i_ready;
    assign do_push = push && (!full || pop);

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_d[wptr] <= word_sh;
            mem_c[wptr] <= map_ch;
            mem_s[wptr] <= map_slot;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CTW'(do_push) - CTW'(pop);
            if (push && !do_push) o_overflow <= 1'b1;
        end
    end

    assign o_valid   = (count != '0);
    assign o_data    = o_valid ? mem_d[rptr] : '0;
    assign o_channel = o_valid ? mem_c[rptr] : '0;
    assign o_slot    = o_valid ? mem_s[rptr] : '0;

endmodule

// File: tb/tb_adat_rx_frame_decoder.sv
// Bench for adat_rx_frame_decoder: table vectors, directed corner
// sequences, and random traffic against a frame-position model.
module tb_adat_rx_frame_decoder;

    localparam int NCH = 8;
    localparam int NIB = 6;
    localparam int DEP = 16;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [4:0]  i_bits;
    logic [2:0]  i_bit_count;
    logic        i_valid;
    logic        i_sync;
    logic [1:0]  i_smux;
    logic [3:0]  o_user;
    logic        o_user_valid;
    logic [23:0] o_data;
    logic [2:0]  o_channel;
    logic [1:0]  o_slot;
    logic        o_valid;
    logic        i_ready;
    logic        o_frame_done;
    logic        o_frame_err;
    logic        o_locked;
    logic        o_overflow;

    adat_rx_frame_decoder dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_bits(i_bits),
        .i_bit_count(i_bit_count), .i_valid(i_valid),
        .i_sync(i_sync), .i_smux(i_smux), .o_user(o_user),
        .o_user_valid(o_user_valid), .o_data(o_data),
        .o_channel(o_channel), .o_slot(o_slot),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_frame_done(o_frame_done), .o_frame_err(o_frame_err),
        .o_locked(o_locked), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct packed {
        logic [23:0] d;
        logic [2:0]  ch;
        logic [1:0]  sl;
    } ent_t;

    // model: pos -1 idle, -2 waiting sync, 0 user, >=1 data groups
    int          pos;
    logic [23:0] acc;
    ent_t        q[$];
    ent_t        cap[$];
    logic [3:0]  m_user;
    logic        m_uv, m_done, m_err, m_locked, m_ovf;

    task automatic model_reset();
        pos = -1; acc = '0; q.delete();
        m_user = '0; m_uv = 0; m_done = 0;
        m_err = 0; m_locked = 0; m_ovf = 0;
    endtask

    task automatic model_step(input logic s, v,
                              input logic [4:0] b,
                              input logic [2:0] c,
                              input logic [1:0] m,
                              input logic r);
        bit bad;
        int k, n;
        ent_t e;
        m_uv = 0; m_done = 0; m_err = 0;
        if (r && q.size() > 0) void'(q.pop_front());
        bad = (c != 3'd5) || !b[0];
        if (s) begin
            if (pos >= 1) m_err = 1;
            pos = 0;
            acc = '0;
        end
        if (v) begin
            if (pos == -2) m_err = 1;
            else if (pos >= 0) begin
                if (bad) begin
                    m_err = 1;
                    pos = -1;
                end else if (pos == 0) begin
                    m_user = b[4:1];
                    m_uv = 1;
                    pos = 1;
                end else begin
                    acc = {acc[19:0], b[4:1]};
                    n = (pos - 1) % NIB;
                    k = (pos - 1) / NIB;
                    pos++;
                    if (n == NIB - 1) begin
                        e.d = acc;
                        if (m == 2'd1) begin
                            e.ch = 3'(k / 2); e.sl = 2'(k % 2);
                        end else if (m == 2'd2) begin
                            e.ch = 3'(k / 4); e.sl = 2'(k % 4);
                        end else begin
                            e.ch = 3'(k); e.sl = 2'd0;
                        end
                        if (q.size() < DEP) q.push_back(e);
                        else m_ovf = 1;
                        acc = '0;
                        if (k == NCH - 1) begin
                            m_done = 1;
                            pos = -2;
                        end
                    end
                end
            end
        end
        if (m_done) m_locked = 1;
        else if (m_err) m_locked = 0;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] a, e);
        n_vec++;
        if (a !== e) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, a, e, $time);
        end
    endtask

    task automatic mchk();
        logic hv;
        ent_t h;
        hv = (q.size() > 0);
        h = hv ? q[0] : '0;
        chk("valid", 32'(o_valid), 32'(hv));
        chk("data", 32'(o_data), 32'(h.d));
        chk("channel", 32'(o_channel), 32'(h.ch));
        chk("slot", 32'(o_slot), 32'(h.sl));
        chk("user", 32'(o_user), 32'(m_user));
        chk("user_valid", 32'(o_user_valid), 32'(m_uv));
        chk("frame_done", 32'(o_frame_done), 32'(m_done));
        chk("frame_err", 32'(o_frame_err), 32'(m_err));
        chk("locked", 32'(o_locked), 32'(m_locked));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
    endtask

    task automatic cyc(input logic s, v,
                       input logic [4:0] b,
                       input logic [2:0] c,
                       input logic [1:0] m,
                       input logic r);
        i_sync = s; i_valid = v; i_bits = b;
        i_bit_count = c; i_smux = m; i_ready = r;
        #1;
        if (o_valid && r)
            cap.push_back('{o_data, o_channel, o_slot});
        @(posedge i_clk);
        model_step(s, v, b, c, m, r);
        #1;
        mchk();
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        i_sync = 0; i_valid = 0; i_bits = '0;
        i_bit_count = '0; i_smux = '0; i_ready = 0;
        #2;
        model_reset();
        mchk();
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
    endtask

    task automatic send_word(input logic [23:0] w,
                             input logic [1:0] m,
                             input logic r);
        for (int i = NIB - 1; i >= 0; i--)
            cyc(0, 1, {w[4*i +: 4], 1'b1}, 3'd5, m, r);
    endtask

    task automatic send_frame(input logic [3:0] u,
                              input int base,
                              input logic [1:0] m,
                              input logic r);
        cyc(1, 0, 5'b0, 3'd5, m, r);
        cyc(0, 1, {u, 1'b1}, 3'd5, m, r);
        for (int k = 0; k < NCH; k++)
            send_word(24'(base + k), m, r);
    endtask

    typedef struct packed {
        logic        s, v;
        logic [4:0]  b;
        logic [2:0]  c;
        logic [3:0]  eu;
        logic        euv, ev;
        logic [23:0] ed;
        logic        ee;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1, 0, 5'b00000, 5, 4'h0, 0, 0, 24'h0, 0};
        tbl[1]  = '{0, 1, 5'b10101, 5, 4'hA, 1, 0, 24'h0, 0};
        tbl[2]  = '{0, 1, 5'b11111, 5, 4'hA, 0, 0, 24'h0, 0};
        tbl[3]  = '{0, 1, 5'b11111, 5, 4'hA, 0, 0, 24'h0, 0};
        tbl[4]  = '{0, 1, 5'b11111, 5, 4'hA, 0, 0, 24'h0, 0};
        tbl[5]  = '{0, 1, 5'b11111, 5, 4'hA, 0, 0, 24'h0, 0};
        tbl[6]  = '{0, 1, 5'b11111, 5, 4'hA, 0, 0, 24'h0, 0};
        tbl[7]  = '{0, 1, 5'b11111, 5, 4'hA, 0, 1,
                    24'hFFFFFF, 0};
        tbl[8]  = '{0, 1, 5'b11110, 5, 4'hA, 0, 1,
                    24'hFFFFFF, 1};
        tbl[9]  = '{0, 1, 5'b00001, 5, 4'hA, 0, 1,
                    24'hFFFFFF, 0};
        tbl[10] = '{1, 1, 5'b00111, 5, 4'h3, 1, 1,
                    24'hFFFFFF, 0};
        tbl[11] = '{0, 1, 5'b00001, 5, 4'h3, 0, 1,
                    24'hFFFFFF, 0};
        tbl[12] = '{1, 0, 5'b00000, 5, 4'h3, 0, 1,
                    24'hFFFFFF, 1};
        tbl[13] = '{0, 1, 5'b11001, 5, 4'hC, 1, 1,
                    24'hFFFFFF, 0};
        tbl[14] = '{0, 1, 5'b00011, 4, 4'hC, 0, 1,
                    24'hFFFFFF, 1};
        tbl[15] = '{0, 1, 5'b00001, 5, 4'hC, 0, 1,
                    24'hFFFFFF, 0};

        i_rst = 1'b0;
        #1;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].s, tbl[i].v, tbl[i].b, tbl[i].c, 2'd0, 0);
            chk($sformatf("tbl%0d_user", i),
                32'(o_user), 32'(tbl[i].eu));
            chk($sformatf("tbl%0d_uv", i),
                32'(o_user_valid), 32'(tbl[i].euv));
            chk($sformatf("tbl%0d_valid", i),
                32'(o_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i),
                32'(o_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_err", i),
                32'(o_frame_err), 32'(tbl[i].ee));
        end

        // first test-plan frame: FF word then seven zero words
        do_reset();
        cyc(1, 0, 5'b0, 3'd5, 2'd0, 0);
        cyc(0, 1, 5'b10101, 3'd5, 2'd0, 0);
        send_word(24'hFFFFFF, 2'd0, 0);
        chk("tp_head", 32'(o_data), 32'hFFFFFF);
        for (int k = 1; k < NCH; k++)
            send_word(24'h0, 2'd0, 0);
        chk("tp_done", 32'(o_frame_done), 32'd1);
        chk("tp_locked", 32'(o_locked), 32'd1);
        cap.delete();
        repeat (10) cyc(0, 0, 5'b0, 3'd5, 2'd0, 1);
        chk("tp_words", 32'(cap.size()), 32'd8);
        for (int i = 0; i < 8 && i < cap.size(); i++) begin
            chk("tp_ch", 32'(cap[i].ch), 32'(i));
            chk("tp_d", 32'(cap[i].d), (i == 0) ? 32'hFFFFFF : 0);
        end

        // S/MUX4 mapping with sink always ready
        cap.delete();
        send_frame(4'h5, 100, 2'd2, 1);
        chk("smux_done", 32'(o_frame_done), 32'd1);
        chk("smux_locked", 32'(o_locked), 32'd1);
        repeat (4) cyc(0, 0, 5'b0, 3'd5, 2'd2, 1);
        chk("smux_words", 32'(cap.size()), 32'd8);
        for (int i = 0; i < 8 && i < cap.size(); i++) begin
            chk("smux_ch", 32'(cap[i].ch), 32'(i / 4));
            chk("smux_slot", 32'(cap[i].sl), 32'(i % 4));
        end

        // WAIT_SYNC group: error and unlock
        cyc(0, 1, 5'b00001, 3'd5, 2'd0, 1);
        chk("ws_err", 32'(o_frame_err), 32'd1);
        chk("ws_unlock", 32'(o_locked), 32'd0);

        // overflow: three frames with no sink
        do_reset();
        for (int f = 0; f < 3; f++)
            send_frame(4'(f), f * NCH, 2'd0, 0);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        cap.delete();
        repeat (20) cyc(0, 0, 5'b0, 3'd5, 2'd0, 1);
        chk("ovf_kept", 32'(cap.size()), 32'd16);
        for (int i = 0; i < 16 && i < cap.size(); i++)
            chk("ovf_order", 32'(cap[i].d), 32'(i));
        chk("ovf_empty", 32'(o_valid), 32'd0);
        chk("ovf_sticky", 32'(o_overflow), 32'd1);

        // randomized traffic, with one reset mid-stream
        do_reset();
        begin
            logic s, v, r;
            logic [4:0] b;
            logic [2:0] c;
            logic [1:0] m;
            int rbias;
            m = 2'd0;
            rbias = 2;
            for (int n = 0; n < 6000; n++) begin
                if (n % 500 == 0) rbias = $urandom_range(0, 3);
                if (n == 3100) do_reset();
                s = ($urandom % 150 == 0);
                v = ($urandom % 4 != 0);
                b = {4'($urandom), ($urandom % 150 != 0)};
                c = ($urandom % 200 == 0) ? 3'($urandom) : 3'd5;
                if ($urandom % 40 == 0) m = 2'($urandom);
                r = ($urandom_range(0, 3) < rbias);
                if ($urandom % 90 == 0) begin
                    s = 1'b1;
                    v = 1'b0;
                end
                cyc(s, v, b, c, m, r);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/adat_rx_frame_decoder.md
# adat_rx_frame_decoder

Parametrised ADAT frame decoder that succeeds the fixed 8-channel frame parser. It sits after the NRZI/bit-group recovery stage and consumes 5-bit groups. Each group holds 4 payload bits and 1 separator bit. The block assembles the user nibble and NUM_CH audio words per frame, checks frame integrity, and maps ADAT channels to S/MUX audio channel/slot pairs. Assembled words are buffered in an output FIFO with a valid/ready handshake toward the audio sink.

## Interface
- NUM_CH, 8, ADAT channels per frame; must be a multiple of 4 and at least 4
- NIB_PER_WORD, 6, nibbles per channel word; DW = 4*NIB_PER_WORD, which gives 24 at the default
- FIFO_DEPTH, 16, output FIFO entries; must be a power of 2 and at least 2
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-low
- i_bits  in  5  group payload; [4:1] data MSB-first, [0] separator (must be 1)
- i_bit_count  in  3  number of valid bits in the group; must be 5 inside a frame
- i_valid  in  1  group strobe, one cycle per group
- i_sync  in  1  one-cycle pulse; a frame sync was detected
- i_smux  in  2  mode: 0 = 1x, 1 = S/MUX2, 2 = S/MUX4, 3 = treated as 1x
- o_user  out  4  user bits of the last accepted frame
- o_user_valid  out  1  one-cycle pulse when o_user updates
- o_data  out  DW  FIFO head word
- o_channel  out  $clog2(NUM_CH)  audio channel of the head word
- o_slot  out  2  S/MUX sample slot of the head word
- o_valid  out  1  FIFO not empty
- i_ready  in  1  sink accepts the head word when o_valid && i_ready
- o_frame_done  out  1  one-cycle pulse after the last word of an error-free frame
- o_frame_err  out  1  one-cycle pulse on any framing error
- o_locked  out  1  set by o_frame_done, cleared by o_frame_err
- o_overflow  out  1  sticky; a word was dropped because the FIFO was full

## Operation
- **States:**
  - IDLE: waiting for sync.
  - USER: expecting the user group.
  - DATA: expecting channel groups.
  - WAIT_SYNC: frame complete, waiting for the next sync.
- **Counters:**
  - Nibble counter, 0..NIB_PER_WORD-1.
  - Channel counter, 0..NUM_CH-1.
- **Sync:**
  - i_sync in any state moves to USER and clears both counters and the partial word.
  - If the state was DATA, or USER after at least one group, the sync also pulses o_frame_err.
  - i_sync and i_valid in the same cycle: the group is processed as the USER group of the new frame.
- **USER:**
  - A valid group latches o_user = i_bits[4:1] and pulses o_user_valid.
  - Next state is DATA.
- **DATA:**
  - Each valid group shifts i_bits[4:1] into the word, MSB first.
  - On the NIB_PER_WORD-th nibble, the word is pushed to the FIFO and the channel counter increments.
  - After channel NUM_CH-1 is pushed, pulse o_frame_done, set o_locked, and go to WAIT_SYNC.
- **Framing errors:**
  - Applies in USER and DATA to any valid group with i_bits[0]==0 or i_bit_count!=5.
  - Response: discard the partial word, keep words already pushed, pulse o_frame_err, clear o_locked, and go to IDLE.
- **Ignored groups:**
  - A valid group in IDLE is ignored, with no error.
  - A valid group in WAIT_SYNC is ignored, pulses o_frame_err, and clears o_locked.
- **Channel mapping** (k = ADAT channel index):
  - 1x: channel = k, slot = 0.
  - S/MUX2: channel = k>>1, slot = k[0].
  - S/MUX4: channel = k>>2, slot = k[1:0].
  - i_smux is sampled when each word is pushed.
- **FIFO:**
  - Show-ahead.
  - A push and a pop in the same cycle are both performed, including when the FIFO is full.
  - A push when full with no pop drops the word and sets o_overflow.
  - o_overflow is cleared only by reset.
  - The read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset values** (async assert, synchronous deassert):
  - State = IDLE and all counters = 0.
  - FIFO empty.
  - All outputs 0: o_user = 0, o_data = 0, channel and slot = 0, and o_valid, o_user_valid, o_frame_done, o_frame_err, o_locked, o_overflow all low.
- **Reset mid-frame:** the partial frame and all FIFO contents are lost.
- **User latency:** o_user and o_user_valid are registered, valid the cycle after the clock edge that samples the USER group.
- **Word push:** happens at the edge that samples the last nibble. o_valid rises the cycle after that edge if the FIFO was empty.
- **Pop:** happens at the edge where o_valid && i_ready. The next head word, or o_valid=0, appears after that edge.
- **Frame-done and error pulses:** o_frame_done is asserted the cycle after the edge that samples the last nibble of the frame. o_frame_err is asserted the cycle after the edge that samples the offending group or sync.
- **Throughput:** one group per cycle is sustained. At most one FIFO push per cycle.
- **Handshake:** o_data, o_channel and o_slot are stable while o_valid && !i_ready.

## Test plan
- Reset, sync, then group 5'b10101 -> o_user=4'b1010, with a one-cycle o_user_valid pulse.
- Continue with 6×5'b11111 -> o_valid=1, o_data=24'hFFFFFF, channel 0, slot 0. Then 7 more words, each 6×5'b00001 -> o_frame_done pulse and o_locked=1, with 8 FIFO entries for channels 0..7 (the last 7 are 24'h000000).
- i_smux=2, full frame, i_ready=1 -> (channel,slot) sequence is (0,0),(0,1),(0,2),(0,3),(1,0),(1,1),(1,2),(1,3).
- Mid-word group 5'b11110 (separator 0) -> o_frame_err pulse, o_locked=0, partial word not pushed. Subsequent groups are ignored until sync.
- Sync asserted after 3 data nibbles -> o_frame_err pulse. The next group is accepted as the user nibble.
- i_ready=0 with FIFO_DEPTH=16 over 3 frames (24 words) -> 16 words retained and o_overflow=1. Then drain with i_ready=1 -> words 0..15 appear in push order, and o_valid falls after the 16th word.
